// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage buffer: state encoding,
// occupancy width and the packed MEM/WB payload field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int OCC_W = 2;

  // MEM/WB payload layout for the default 70-bit width
  localparam int REGWRITE_BIT  = 69;
  localparam int MEMTOREG_BIT  = 68;
  localparam int ALURESULT_MSB = 67;
  localparam int ALURESULT_LSB = 36;
  localparam int READDATA_MSB  = 35;
  localparam int READDATA_LSB  = 4;
  localparam int RDADDR_MSB    = 3;
  localparam int RDADDR_LSB    = 0;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with a 0..2 increment per cycle; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc_i};
    cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating count of beats squashed by flush.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W    = 70,
  parameter int SKID         = 1,
  parameter int CLR_ON_FLUSH = 1,
  parameter int CNT_W        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [OCC_W-1:0]     occupancy_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: a beat moves on a posedge where valid and ready are both high.
  // Once out_valid_o rises, out_data_o is held until out_ready_i accepts it.
  logic [1:0] drop_inc;

  if (SKID != 0) begin : g_skid
    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d, skid_q, skid_d;
    logic                 ready_q, in_xfer, out_xfer;

    assign in_xfer  = in_valid_i & ready_q;
    assign out_xfer = (state_q != ST_EMPTY) & out_ready_i;

    always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      drop_inc = 2'd0;
      if (flush_i) begin
        state_d = ST_EMPTY;
        if (CLR_ON_FLUSH != 0) begin
          main_d = '0;
          skid_d = '0;
        end
        // Held beats minus the one leaving downstream, plus the one swallowed.
        drop_inc = 2'(state_q) - {1'b0, out_xfer} + {1'b0, in_xfer};
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_d = ST_BUSY;
              main_d  = in_data_i;
            end
          end
          ST_BUSY: begin
            case ({in_xfer, out_xfer})
              2'b11: main_d = in_data_i;
              2'b10: begin
                state_d = ST_FULL;
                skid_d  = in_data_i;
              end
              2'b01: state_d = ST_EMPTY;
              default: state_d = ST_BUSY;
            endcase
          end
          ST_FULL: begin
            if (out_xfer) begin
              state_d = ST_BUSY;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != ST_FULL);
      end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = OCC_W'(state_q);
    assign dbg_state_o = state_q;
  end else begin : g_noskid
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic                 valid_q, valid_d, ready, in_xfer, out_xfer;

    // Combinational ready: a full register may still load when the held beat leaves.
    assign ready    = ~valid_q | out_ready_i;
    assign in_xfer  = in_valid_i & ready;
    assign out_xfer = valid_q & out_ready_i;

    always_comb begin
      main_d   = main_q;
      valid_d  = valid_q;
      drop_inc = 2'd0;
      if (flush_i) begin
        valid_d = 1'b0;
        if (CLR_ON_FLUSH != 0) main_d = '0;
        drop_inc = {1'b0, valid_q & ~out_ready_i} + {1'b0, in_xfer};
      end else if (in_xfer) begin
        main_d  = in_data_i;
        valid_d = 1'b1;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        main_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        main_q  <= main_d;
        valid_q <= valid_d;
      end
    end

    assign in_ready_o  = ready;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = {{(OCC_W-1){1'b0}}, valid_q};
    assign dbg_state_o = valid_q ? ST_BUSY : ST_EMPTY;
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: scoreboarded SKID=1 stage plus directed checks on
// a SKID=0 stage and a narrow-counter stage for saturation.
module tb_pipe_stage_buf;

  localparam int W = 70;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance: SKID=1, CNT_W=8
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occ, dbg_state;
  logic [7:0]   drop_cnt;

  // SKID=0 instance
  logic         z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [W-1:0] z_in_data, z_out_data;
  logic [1:0]   z_occ, z_dbg_state;
  logic [7:0]   z_drop_cnt;

  // CNT_W=2 instance
  logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [W-1:0] c_in_data, c_out_data;
  logic [1:0]   c_occ, c_dbg_state;
  logic [1:0]   c_drop_cnt;

  pipe_stage_buf #(.PAYLOAD_W(W), .SKID(1), .CLR_ON_FLUSH(1), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occupancy_o(occ), .drop_cnt_o(drop_cnt), .dbg_state_o(dbg_state)
  );

  pipe_stage_buf #(.PAYLOAD_W(W), .SKID(0), .CLR_ON_FLUSH(1), .CNT_W(8)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(z_flush),
    .in_valid_i(z_in_valid), .in_ready_o(z_in_ready), .in_data_i(z_in_data),
    .out_valid_o(z_out_valid), .out_ready_i(z_out_ready), .out_data_o(z_out_data),
    .occupancy_o(z_occ), .drop_cnt_o(z_drop_cnt), .dbg_state_o(z_dbg_state)
  );

  pipe_stage_buf #(.PAYLOAD_W(W), .SKID(1), .CLR_ON_FLUSH(1), .CNT_W(2)) dutc (
    .clk_i(clk), .rst_i(rst_n), .flush_i(c_flush),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .occupancy_o(c_occ), .drop_cnt_o(c_drop_cnt), .dbg_state_o(c_dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int drop_exp = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat presented by the main instance must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected no beat at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle on the main instance; entered and left at posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic fl, output logic acc);
    chk("occupancy", W'(occ), W'(exp_q.size()));
    chk("state", W'(dbg_state), W'(exp_q.size()));
    chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
    chk("drop_cnt", W'(drop_cnt), W'(drop_exp));
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    acc = v & in_ready;
    if (fl) begin
      drop_exp = drop_exp + exp_q.size() + int'(acc);
      if (drop_exp > 255) drop_exp = 255;
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic ordy);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, d, ordy, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, acc);
  endtask

  logic acc_t;
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b1; in_data = W'(70'h77); out_ready = 1'b0;
    z_flush = 1'b0; z_in_valid = 1'b1; z_in_data = W'(70'h77); z_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b1; c_in_data = W'(70'h77); c_out_ready = 1'b0;

    // Reset with valid input asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_drop_cnt", W'(drop_cnt), W'(0));
    chk("rst_occ", W'(occ), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_z_out_valid", W'(z_out_valid), W'(0));
    chk("rst_c_drop_cnt", W'(c_drop_cnt), W'(0));
    in_valid = 1'b0; z_in_valid = 1'b0; c_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming 0x1..0x8 at full rate
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b1);
    idle(1'b1, 2);

    // Stall: 0xA, 0xB fill the stage, 0xC is refused until space frees
    send(W'(70'hA), 1'b0);
    send(W'(70'hB), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(70'hC), 1'b0, 1'b0, acc_t);
      chk("stall_reject", W'(acc_t), W'(0));
      chk("stall_hold", out_data, W'(70'hA));
    end
    send(W'(70'hC), 1'b1);
    idle(1'b1, 3);

    // Flush while FULL with an offered beat that cannot be accepted
    send(W'(70'h1A), 1'b0);
    send(W'(70'h1B), 1'b0);
    step(1'b1, W'(70'h1D), 1'b0, 1'b1, acc_t);
    chk("fl_full_valid", W'(out_valid), W'(0));
    chk("fl_full_occ", W'(occ), W'(0));
    chk("fl_full_drop", W'(drop_cnt), W'(2));
    chk("fl_full_data", out_data, W'(0));
    chk("fl_full_ready", W'(in_ready), W'(1));

    // Flush in BUSY: held beat delivered, incoming beat dropped
    send(W'(70'h11), 1'b0);
    step(1'b1, W'(70'h22), 1'b1, 1'b1, acc_t);
    chk("fl_busy_drop", W'(drop_cnt), W'(3));
    chk("fl_busy_valid", W'(out_valid), W'(0));
    idle(1'b1, 2);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    // Saturation on the 2-bit counter: five single drops
    c_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_in_valid = 1'b1;
      c_in_data  = W'(i + 1);
      c_flush    = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_drop", W'(c_drop_cnt), W'(sat_exp[i]));
    end
    c_in_valid = 1'b0;
    c_flush    = 1'b0;

    // SKID=0: held beat blocks input, release loads the next beat with no bubble
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_data   = W'(70'h5);
    chk("z_ready_empty", W'(z_in_ready), W'(1));
    @(posedge clk);
    #1;
    chk("z_valid_5", W'(z_out_valid), W'(1));
    chk("z_data_5", z_out_data, W'(70'h5));
    chk("z_ready_stall", W'(z_in_ready), W'(0));
    chk("z_occ_1", W'(z_occ), W'(1));
    z_out_ready = 1'b1;
    z_in_data   = W'(70'h6);
    #1;
    chk("z_ready_release", W'(z_in_ready), W'(1));
    @(posedge clk);
    #1;
    chk("z_valid_6", W'(z_out_valid), W'(1));
    chk("z_data_6", z_out_data, W'(70'h6));
    z_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("z_valid_done", W'(z_out_valid), W'(0));
    chk("z_occ_0", W'(z_occ), W'(0));
    chk("z_drop_none", W'(z_drop_cnt), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
